writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final pipeline stage (WB). Registers the MEM-stage result, selects between ALU result and load data, and aligns and extends sub-word loads.
- Acts as the writer side of the decode-stage register bank: drives DIR_WRA, DI and the active-low REG_WR strobe.
- Provides bypass-match flags so decode can forward a pending write, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- reloj  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MEM_VALID  in  1  MEM stage presents a valid instruction.
- STALL  in  1  freeze WB register; no capture.
- ALU_RES  in  32  ALU result from MEM stage.
- MEM_DATA  in  32  raw word read from data memory.
- DIR_DEST  in  5  destination register.
- REG_WRITE  in  1  instruction writes a register.
- MEM_TO_REG  in  1  1 = load data, 0 = ALU_RES.
- LOAD_SIZE  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- LOAD_SIGNED  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- DIR_A, DIR_B  in  5 each  decode read addresses, used for bypass compare.
- DIR_WRA  out  5  write address to register bank.
- DI  out  32  write data to register bank.
- REG_WR  out  1  active-low write strobe.
- FWD_A, FWD_B  out  1 each  pending write matches DIR_A / DIR_B.
- MISALIGN  out  1  sticky misaligned-load flag.
- RETIRED  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous, reloj edge with reset=1) clears:
  - stage valid bit, captured fields, written flag → 0.
  - Outputs: DIR_WRA=0, DI=0, REG_WR=1, FWD_A=FWD_B=0, MISALIGN=0, RETIRED=0.
  - Reset overrides STALL and MEM_VALID.
- Capture:
  - On rising edge with STALL=0, the stage loads MEM_VALID plus all MEM fields, and the byte offset ALU_RES[1:0]. The written flag clears.
  - With STALL=1 all fields hold. Latency is 1 cycle from MEM inputs to REG_WR/DI.
  - A bubble (MEM_VALID=0, STALL=0) loads valid=0.
- Data select (combinational from stage register):
  - MEM_TO_REG=0 → DI = captured ALU_RES.
  - MEM_TO_REG=1, word → DI = MEM_DATA.
  - MEM_TO_REG=1, half, little-endian → ofs[1]=0 selects bits 15:0, ofs[1]=1 selects bits 31:16. Then extend to 32 bits per LOAD_SIGNED.
  - MEM_TO_REG=1, byte → byte lane ofs×8+7 : ofs×8, extended per LOAD_SIGNED.
- Misalignment:
  - Condition: MEM_TO_REG=1 and (word with ofs≠00, or half with ofs[0]=1).
  - Effect: the write is suppressed and MISALIGN sets. MISALIGN stays set until reset.
  - The instruction still counts as retired.
- Write enable:
  - Required conditions: valid, REG_WRITE=1, DIR_DEST≠0, not misaligned, written flag=0.
  - When all hold, REG_WR=0 for that cycle.
  - Register 0 is never written. DIR_WRA = DIR_DEST at all times.
- Single strobe under stall:
  - The edge ending a cycle in which a valid instruction was present sets the written flag. A valid instruction is retired exactly once.
  - While STALL holds the same instruction, REG_WR=1 and RETIRED does not advance.
- Retire counter:
  - RETIRED increments by 1 on each rising edge where valid=1 and written=0. It wraps modulo 2^CNT_W.
  - Simultaneous capture and retire of the previous instruction is the normal case; both happen on the same edge.
- Bypass:
  - FWD_A = REG_WR==0 and DIR_DEST==DIR_A. FWD_B likewise with DIR_B.
  - When set, decode must use DI instead of the bank output. Flags are 0 for register 0 and for suppressed writes.
- Reset mid-operation: a pending write is discarded and no strobe is issued after reset.

Test Plan:
- ALU writeback: MEM_VALID=1, REG_WRITE=1, MEM_TO_REG=0, ALU_RES=0x0000_1234, DIR_DEST=5 → next cycle REG_WR=0, DIR_WRA=5, DI=0x1234; RETIRED=1 after following edge.
- Signed byte load: MEM_DATA=0x12F0_5678, LOAD_SIZE=10, LOAD_SIGNED=1, ALU_RES[1:0]=10 → DI=0xFFFF_FFF0. Same with LOAD_SIGNED=0 → DI=0x0000_00F0.
- Halfword/misalign: half, ofs=10, MEM_DATA=0x8001_0000, signed → DI=0xFFFF_8001, write occurs. Half with ofs=01 → REG_WR stays 1, MISALIGN=1, RETIRED still increments.
- Register 0 and bypass: DIR_DEST=0 → REG_WR=1, FWD_A=0. DIR_DEST=7 with DIR_A=7, DIR_B=3 → FWD_A=1, FWD_B=0 during the strobe cycle.
- Stall: capture write to r9, then STALL=1 for 3 cycles → exactly one REG_WR=0 cycle; RETIRED advances by 1 only.
- Reset mid-op: assert reset while a valid write is captured → all outputs at reset values on the next edge, no later strobe, RETIRED=0.

Source files
------------

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit
//  Purpose  : Final (WB) pipeline stage. It registers the MEM-stage result,
//             selects the ALU result or aligned/extended load data, and
//             drives the write side of the decode register bank. It also
//             raises bypass-match flags for decode and counts retired
//             instructions.
//  Ports    : reloj/reset              clock (rising) / sync active-high reset
//             MEM_VALID, STALL         stage capture control
//             ALU_RES, MEM_DATA        MEM-stage result and raw load word
//             DIR_DEST, REG_WRITE,
//             MEM_TO_REG, LOAD_SIZE,
//             LOAD_SIGNED              destination and writeback controls
//             DIR_A, DIR_B             decode read addresses (bypass compare)
//             DIR_WRA, DI, REG_WR      register-bank write port (REG_WR low)
//             FWD_A, FWD_B             pending write matches DIR_A / DIR_B
//             MISALIGN                 sticky misaligned-load flag
//             RETIRED                  retired-instruction count
//  Revision : 1.0  initial release
// ============================================================================
module writeback_unit #(
    parameter int CNT_W = 32
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             MEM_VALID,
    input  logic             STALL,
    input  logic [31:0]      ALU_RES,
    input  logic [31:0]      MEM_DATA,
    input  logic [4:0]       DIR_DEST,
    input  logic             REG_WRITE,
    input  logic             MEM_TO_REG,
    input  logic [1:0]       LOAD_SIZE,
    input  logic             LOAD_SIGNED,
    input  logic [4:0]       DIR_A,
    input  logic [4:0]       DIR_B,
    output logic [4:0]       DIR_WRA,
    output logic [31:0]      DI,
    output logic             REG_WR,
    output logic             FWD_A,
    output logic             FWD_B,
    output logic             MISALIGN,
    output logic [CNT_W-1:0] RETIRED
);

    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_byte = 2'b10;

    // Stage register
    logic             r_valid;
    logic [31:0]      r_alu;
    logic [31:0]      r_mem_data;
    logic [4:0]       r_dest;
    logic             r_reg_write;
    logic             r_mem_to_reg;
    logic [1:0]       r_load_size;
    logic             r_load_signed;
    logic             r_written;
    logic             r_misalign;
    logic [CNT_W-1:0] r_retired;

    logic [1:0]       w_ofs;
    logic [15:0]      w_half;
    logic [7:0]       w_byte;
    logic [31:0]      w_load;
    logic             w_is_word;
    logic             w_misalign;
    logic             w_we;

    // The byte offset is simply the low bits of the captured address.
    assign w_ofs = r_alu[1:0];

    always_comb begin
        w_half = w_ofs[1] ? r_mem_data[31:16] : r_mem_data[15:0];
        case (w_ofs)
            2'b00:   w_byte = r_mem_data[7:0];
            2'b01:   w_byte = r_mem_data[15:8];
            2'b10:   w_byte = r_mem_data[23:16];
            default: w_byte = r_mem_data[31:24];
        endcase
        case (r_load_size)
            c_size_half: w_load = {{16{r_load_signed & w_half[15]}}, w_half};
            c_size_byte: w_load = {{24{r_load_signed & w_byte[7]}}, w_byte};
            default:     w_load = r_mem_data;   // 00 and 11 both mean word
        endcase
    end

    assign w_is_word  = (r_load_size != c_size_half) && (r_load_size != c_size_byte);
    assign w_misalign = r_mem_to_reg &&
                        ((w_is_word && (w_ofs != 2'b00)) ||
                         ((r_load_size == c_size_half) && w_ofs[0]));

    // The written flag blocks a second strobe while STALL holds the same
    // instruction in the stage.
    assign w_we = r_valid && r_reg_write && (r_dest != 5'd0) &&
                  !w_misalign && !r_written;

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_alu         <= 32'd0;
            r_mem_data    <= 32'd0;
            r_dest        <= 5'd0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_load_size   <= 2'b00;
            r_load_signed <= 1'b0;
            r_written     <= 1'b0;
            r_misalign    <= 1'b0;
            r_retired     <= '0;
        end else begin
            if (r_valid && !r_written) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (r_valid && w_misalign) begin
                r_misalign <= 1'b1;
            end
            if (!STALL) begin
                r_valid       <= MEM_VALID;
                r_alu         <= ALU_RES;
                r_mem_data    <= MEM_DATA;
                r_dest        <= DIR_DEST;
                r_reg_write   <= REG_WRITE;
                r_mem_to_reg  <= MEM_TO_REG;
                r_load_size   <= LOAD_SIZE;
                r_load_signed <= LOAD_SIGNED;
                r_written     <= 1'b0;
            end else if (r_valid) begin
                r_written <= 1'b1;
            end
        end
    end

    assign DIR_WRA  = r_dest;
    assign DI       = r_mem_to_reg ? w_load : r_alu;
    assign REG_WR   = !w_we;
    assign FWD_A    = w_we && (r_dest == DIR_A);
    assign FWD_B    = w_we && (r_dest == DIR_B);
    // Flag shows during the offending WB cycle and stays until reset.
    assign MISALIGN = r_misalign || (r_valid && w_misalign);
    assign RETIRED  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_unit
//  Purpose  : Self-checking bench for writeback_unit. Expected register-bank
//             writes are queued when an instruction is driven and popped when
//             the strobe appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_writeback_unit;

    localparam int c_cnt_w = 32;

    logic               reloj = 1'b0;
    logic               reset;
    logic               MEM_VALID, STALL, REG_WRITE, MEM_TO_REG, LOAD_SIGNED;
    logic [31:0]        ALU_RES, MEM_DATA;
    logic [4:0]         DIR_DEST, DIR_A, DIR_B;
    logic [1:0]         LOAD_SIZE;
    logic [4:0]         DIR_WRA;
    logic [31:0]        DI;
    logic               REG_WR, FWD_A, FWD_B, MISALIGN;
    logic [c_cnt_w-1:0] RETIRED;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t                exp_q[$];
    wr_t                e;
    int                 n_checks = 0;
    int                 n_pass   = 0;
    logic [c_cnt_w-1:0] exp_retired = '0;

    writeback_unit #(.CNT_W(c_cnt_w)) dut (
        .reloj(reloj), .reset(reset), .MEM_VALID(MEM_VALID), .STALL(STALL),
        .ALU_RES(ALU_RES), .MEM_DATA(MEM_DATA), .DIR_DEST(DIR_DEST),
        .REG_WRITE(REG_WRITE), .MEM_TO_REG(MEM_TO_REG), .LOAD_SIZE(LOAD_SIZE),
        .LOAD_SIGNED(LOAD_SIGNED), .DIR_A(DIR_A), .DIR_B(DIR_B),
        .DIR_WRA(DIR_WRA), .DI(DI), .REG_WR(REG_WR), .FWD_A(FWD_A),
        .FWD_B(FWD_B), .MISALIGN(MISALIGN), .RETIRED(RETIRED)
    );

    always #5 reloj = ~reloj;

    // Advance one edge; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic drive_instr(input logic [31:0] alu, input logic [31:0] mem,
                               input logic [4:0] dest, input logic m2r,
                               input logic [1:0] size, input logic sgn);
        MEM_VALID = 1'b1; ALU_RES = alu; MEM_DATA = mem; DIR_DEST = dest;
        REG_WRITE = 1'b1; MEM_TO_REG = m2r; LOAD_SIZE = size; LOAD_SIGNED = sgn;
    endtask

    task automatic drive_bubble();
        MEM_VALID = 1'b0; ALU_RES = 32'd0; MEM_DATA = 32'd0; DIR_DEST = 5'd0;
        REG_WRITE = 1'b0; MEM_TO_REG = 1'b0; LOAD_SIZE = 2'b00; LOAD_SIGNED = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; STALL = 1'b1; DIR_A = 5'd0; DIR_B = 5'd0;
        drive_instr(32'hDEAD_BEEF, 32'h1, 5'd4, 1'b0, 2'b00, 1'b0);
        tick(); tick();
        n_checks++;
        if ({DIR_WRA, DI, REG_WR, FWD_A, FWD_B, MISALIGN} !== {5'd0, 32'd0, 1'b1, 3'b000})
            $display("FAIL reset_outputs: got wra=%0d di=%h wr=%b fa=%b fb=%b mis=%b, want 0 0 1 0 0 0",
                     DIR_WRA, DI, REG_WR, FWD_A, FWD_B, MISALIGN);
        else n_pass++;
        n_checks++;
        if (RETIRED !== '0) $display("FAIL reset_retired: got %0d want 0", RETIRED);
        else n_pass++;
        reset = 1'b0; STALL = 1'b0;
        drive_bubble();
        tick();
    endtask

    task automatic test_alu_wb();
        drive_instr(32'h0000_1234, 32'h0, 5'd5, 1'b0, 2'b00, 1'b0);
        exp_q.push_back('{addr: 5'd5, data: 32'h0000_1234});
        tick();
        drive_bubble();
        n_checks++;
        if (REG_WR !== 1'b0 || exp_q.size() == 0)
            $display("FAIL alu_strobe: got REG_WR=%b want 0", REG_WR);
        else begin
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (DIR_WRA !== e.addr || DI !== e.data)
                $display("FAIL alu_data: got wra=%0d di=%h want wra=%0d di=%h", DIR_WRA, DI, e.addr, e.data);
            else n_pass++;
        end
        exp_retired = exp_retired + 1;
        tick();
        n_checks++;
        if (RETIRED !== exp_retired || REG_WR !== 1'b1)
            $display("FAIL alu_retired: got ret=%0d wr=%b want ret=%0d wr=1", RETIRED, REG_WR, exp_retired);
        else n_pass++;
    endtask

    // Two loads issued back to back: the second is captured on the edge that
    // retires the first.
    task automatic test_byte_load();
        drive_instr(32'h0000_0102, 32'h12F0_5678, 5'd6, 1'b1, 2'b10, 1'b1);
        exp_q.push_back('{addr: 5'd6, data: 32'hFFFF_FFF0});
        tick();
        drive_instr(32'h0000_0102, 32'h12F0_5678, 5'd6, 1'b1, 2'b10, 1'b0);
        exp_q.push_back('{addr: 5'd6, data: 32'h0000_00F0});
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (REG_WR !== 1'b0 || exp_q.size() == 0)
                $display("FAIL byte_strobe%0d: got REG_WR=%b want 0", i, REG_WR);
            else begin
                n_pass++;
                e = exp_q.pop_front();
                n_checks++;
                if (DIR_WRA !== e.addr || DI !== e.data)
                    $display("FAIL byte_data%0d: got wra=%0d di=%h want wra=%0d di=%h",
                             i, DIR_WRA, DI, e.addr, e.data);
                else n_pass++;
            end
            exp_retired = exp_retired + 1;
            tick();
            drive_bubble();
        end
        n_checks++;
        if (RETIRED !== exp_retired) $display("FAIL byte_retired: got %0d want %0d", RETIRED, exp_retired);
        else n_pass++;
    endtask

    task automatic test_half_misalign();
        drive_instr(32'h0000_0002, 32'h8001_0000, 5'd8, 1'b1, 2'b01, 1'b1);
        exp_q.push_back('{addr: 5'd8, data: 32'hFFFF_8001});
        tick();
        drive_instr(32'h0000_0001, 32'h8001_0000, 5'd8, 1'b1, 2'b01, 1'b1);
        n_checks++;
        if (REG_WR !== 1'b0 || exp_q.size() == 0)
            $display("FAIL half_strobe: got REG_WR=%b want 0", REG_WR);
        else begin
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (DIR_WRA !== e.addr || DI !== e.data)
                $display("FAIL half_data: got wra=%0d di=%h want wra=%0d di=%h", DIR_WRA, DI, e.addr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (MISALIGN !== 1'b0) $display("FAIL half_no_misalign: got %b want 0", MISALIGN);
        else n_pass++;
        exp_retired = exp_retired + 1;
        tick();
        drive_bubble();
        n_checks++;
        if (REG_WR !== 1'b1 || MISALIGN !== 1'b1 || FWD_A !== 1'b0)
            $display("FAIL misalign_cycle: got wr=%b mis=%b fa=%b want wr=1 mis=1 fa=0", REG_WR, MISALIGN, FWD_A);
        else n_pass++;
        exp_retired = exp_retired + 1;
        tick();
        n_checks++;
        if (RETIRED !== exp_retired || MISALIGN !== 1'b1)
            $display("FAIL misalign_after: got ret=%0d mis=%b want ret=%0d mis=1", RETIRED, MISALIGN, exp_retired);
        else n_pass++;
    endtask

    task automatic test_reg0_bypass();
        DIR_A = 5'd0; DIR_B = 5'd0;
        drive_instr(32'h0000_00AA, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0);
        tick();
        drive_bubble();
        n_checks++;
        if (REG_WR !== 1'b1 || FWD_A !== 1'b0)
            $display("FAIL reg0: got wr=%b fa=%b want wr=1 fa=0", REG_WR, FWD_A);
        else n_pass++;
        exp_retired = exp_retired + 1;
        tick();
        DIR_A = 5'd7; DIR_B = 5'd3;
        drive_instr(32'h0000_0777, 32'h0, 5'd7, 1'b0, 2'b00, 1'b0);
        exp_q.push_back('{addr: 5'd7, data: 32'h0000_0777});
        tick();
        drive_bubble();
        n_checks++;
        if (REG_WR !== 1'b0 || exp_q.size() == 0)
            $display("FAIL byp_strobe: got REG_WR=%b want 0", REG_WR);
        else begin
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (DIR_WRA !== e.addr || DI !== e.data)
                $display("FAIL byp_data: got wra=%0d di=%h want wra=%0d di=%h", DIR_WRA, DI, e.addr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (FWD_A !== 1'b1 || FWD_B !== 1'b0)
            $display("FAIL byp_flags: got fa=%b fb=%b want fa=1 fb=0", FWD_A, FWD_B);
        else n_pass++;
        exp_retired = exp_retired + 1;
        tick();
        n_checks++;
        if (FWD_A !== 1'b0 || RETIRED !== exp_retired)
            $display("FAIL byp_after: got fa=%b ret=%0d want fa=0 ret=%0d", FWD_A, RETIRED, exp_retired);
        else n_pass++;
    endtask

    task automatic test_stall();
        int strobes;
        strobes = 0;
        drive_instr(32'h0000_0099, 32'h0, 5'd9, 1'b0, 2'b00, 1'b0);
        exp_q.push_back('{addr: 5'd9, data: 32'h0000_0099});
        tick();
        drive_bubble();
        STALL = 1'b1;
        if (REG_WR === 1'b0) strobes++;
        n_checks++;
        if (REG_WR !== 1'b0 || exp_q.size() == 0)
            $display("FAIL stall_strobe: got REG_WR=%b want 0", REG_WR);
        else begin
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (DIR_WRA !== e.addr || DI !== e.data)
                $display("FAIL stall_data: got wra=%0d di=%h want wra=%0d di=%h", DIR_WRA, DI, e.addr, e.data);
            else n_pass++;
        end
        exp_retired = exp_retired + 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (REG_WR === 1'b0) strobes++;
            n_checks++;
            if (RETIRED !== exp_retired)
                $display("FAIL stall_retired%0d: got %0d want %0d", i, RETIRED, exp_retired);
            else n_pass++;
        end
        STALL = 1'b0;
        tick();
        if (REG_WR === 1'b0) strobes++;
        n_checks++;
        if (strobes != 1 || RETIRED !== exp_retired)
            $display("FAIL stall_once: got strobes=%0d ret=%0d want strobes=1 ret=%0d", strobes, RETIRED, exp_retired);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        int strobes;
        strobes = 0;
        drive_instr(32'h0000_0AAA, 32'h0, 5'd10, 1'b0, 2'b00, 1'b0);
        tick();
        reset = 1'b1;
        drive_instr(32'h0000_0BBB, 32'h0, 5'd11, 1'b0, 2'b00, 1'b0);
        tick();
        exp_retired = '0;
        n_checks++;
        if ({DIR_WRA, DI, REG_WR, FWD_A, FWD_B, MISALIGN} !== {5'd0, 32'd0, 1'b1, 3'b000} || RETIRED !== '0)
            $display("FAIL midop_reset: got wra=%0d di=%h wr=%b fa=%b fb=%b mis=%b ret=%0d, want all reset values",
                     DIR_WRA, DI, REG_WR, FWD_A, FWD_B, MISALIGN, RETIRED);
        else n_pass++;
        reset = 1'b0;
        drive_bubble();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (REG_WR === 1'b0) strobes++;
        end
        n_checks++;
        if (strobes != 0 || RETIRED !== exp_retired || exp_q.size() != 0)
            $display("FAIL midop_after: got strobes=%0d ret=%0d pending=%0d want 0 0 0",
                     strobes, RETIRED, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; STALL = 1'b0; DIR_A = 5'd0; DIR_B = 5'd0;
        drive_bubble();
        test_reset();
        test_alu_wb();
        test_byte_load();
        test_half_misalign();
        test_reg0_bypass();
        test_stall();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
